// File: rtl/mem_access_pkg.sv
// Shared types and constants for the multicycle-CPU memory access stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mau_state_t;

    localparam int unsigned LAT_W = 3;

    // Instruction register field bit positions
    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter timing the memory latency; saturates at zero.
module mem_latency_counter
    import mem_access_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [LAT_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - LAT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Sequences control-unit read/write pulses into fixed-latency memory
// transactions and captures read data into IR or MDR.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        IouD,
    input  logic        load_ir,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [5:0]  OPcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] mdr_out,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        proto_err
);

    mau_state_t       state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             tgt_ir_q, tgt_ir_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      mdr_q, mdr_d;
    logic             misaligned_q, misaligned_d;
    logic             proto_err_q, proto_err_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [LAT_W-1:0] cnt_val;
    logic [31:0]      sel_addr;

    assign sel_addr = IouD ? alu_out_in : pc_in;

    mem_latency_counter u_lat_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            tgt_ir_q     <= 1'b0;
            ir_q         <= '0;
            mdr_q        <= '0;
            misaligned_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            tgt_ir_q     <= tgt_ir_d;
            ir_q         <= ir_d;
            mdr_q        <= mdr_d;
            misaligned_q <= misaligned_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // DONE accepts new requests exactly like IDLE so reads can run back-to-back
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        tgt_ir_d     = tgt_ir_q;
        ir_d         = ir_q;
        mdr_d        = mdr_q;
        misaligned_d = 1'b0;
        proto_err_d  = proto_err_q;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_read && req_write) begin
                    proto_err_d = 1'b1;
                end else if (req_read || req_write) begin
                    if (sel_addr[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else begin
                        mem_addr_d = sel_addr;
                        tgt_ir_d   = load_ir;
                        cnt_load   = 1'b1;
                        if (req_read) begin
                            mem_rd_d = 1'b1;
                            cnt_val  = LAT_W'(READ_LATENCY);
                            state_d  = RD_WAIT;
                        end else begin
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = wdata_in;
                            cnt_val     = LAT_W'(WRITE_LATENCY);
                            state_d     = WR_WAIT;
                        end
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (req_read || req_write) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = DONE;
                    if (state_q == RD_WAIT) begin
                        if (tgt_ir_q) begin
                            ir_d = mem_rdata;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign ir_out     = ir_q;
    assign mdr_out    = mdr_q;
    assign misaligned = misaligned_q;
    assign proto_err  = proto_err_q;
    assign busy       = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign done       = (state_q == DONE);

    assign OPcode = ir_q[OP_HI:OP_LO];
    assign rs     = ir_q[RS_HI:RS_LO];
    assign rt     = ir_q[RT_HI:RT_LO];
    assign rd     = ir_q[RD_HI:RD_LO];
    assign funct  = ir_q[FUNCT_HI:FUNCT_LO];
    assign imm16  = ir_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: instance a uses default latencies, instance b uses READ_LATENCY=3.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_read, req_write, IouD, load_ir;
    logic [31:0] pc_in, alu_out_in, wdata_in;

    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_ir, a_mdr;
    logic        a_mem_rd, a_mem_wr, a_busy, a_done, a_mis, a_perr;
    logic [5:0]  a_op, a_funct;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_imm;

    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_ir, b_mdr;
    logic        b_mem_rd, b_mem_wr, b_busy, b_done, b_mis, b_perr;
    logic [5:0]  b_op, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_access_unit u_a (
        .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
        .IouD(IouD), .load_ir(load_ir), .pc_in(pc_in), .alu_out_in(alu_out_in),
        .wdata_in(wdata_in), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .ir_out(a_ir), .OPcode(a_op),
        .rs(a_rs), .rt(a_rt), .rd(a_rd), .funct(a_funct), .imm16(a_imm), .mdr_out(a_mdr),
        .busy(a_busy), .done(a_done), .misaligned(a_mis), .proto_err(a_perr)
    );

    mem_access_unit #(.READ_LATENCY(3), .WRITE_LATENCY(1)) u_b (
        .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
        .IouD(IouD), .load_ir(load_ir), .pc_in(pc_in), .alu_out_in(alu_out_in),
        .wdata_in(wdata_in), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .ir_out(b_ir), .OPcode(b_op),
        .rs(b_rs), .rt(b_rt), .rd(b_rd), .funct(b_funct), .imm16(b_imm), .mdr_out(b_mdr),
        .busy(b_busy), .done(b_done), .misaligned(b_mis), .proto_err(b_perr)
    );

    // Word memories; read data is garbage until the latency has elapsed
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [7:0]  pend_b;
    int unsigned cd_b = 0;

    always @(posedge clock) begin
        if (a_mem_wr) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
        if (a_mem_rd) a_mem_rdata <= mem_a[a_mem_addr[9:2]];
        else          a_mem_rdata <= 32'hBAD0_BAD0;
    end

    always @(posedge clock) begin
        if (b_mem_wr) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
        if (b_mem_rd) begin
            pend_b      <= b_mem_addr[9:2];
            cd_b        <= 2;
            b_mem_rdata <= 32'hBAD0_BAD0;
        end else if (cd_b != 0) begin
            cd_b        <= cd_b - 1;
            b_mem_rdata <= (cd_b == 1) ? mem_b[pend_b] : 32'hBAD0_BAD0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_read = 0; req_write = 0; IouD = 0; load_ir = 0;
        pc_in = '0; alu_out_in = '0; wdata_in = '0;
        idle(2);
        total++; if ({a_ir, a_mdr, a_mem_addr, a_mem_wdata} !== 128'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {a_ir, a_mdr, a_mem_addr, a_mem_wdata}); end
        total++; if ({a_mem_rd, a_mem_wr, a_busy, a_done, a_mis, a_perr} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {a_mem_rd, a_mem_wr, a_busy, a_done, a_mis, a_perr}); end
        total++; if ({b_ir, b_mdr, b_busy, b_done} !== 66'h0) begin bad++; $display("FAIL reset_b got=%h exp=0", {b_ir, b_mdr, b_busy, b_done}); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_read_ir();
        pc_in = 32'h0000_0040; IouD = 0; load_ir = 1; req_read = 1;
        tick();  // edge N
        req_read = 0;
        total++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 32'h40) begin bad++; $display("FAIL rd_strobe got=%b/%h exp=1/00000040", a_mem_rd, a_mem_addr); end
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", a_busy); end
        tick();  // N+1
        total++; if (a_mem_rd !== 1'b0 || a_ir !== 32'h0) begin bad++; $display("FAIL rd_n1 got=%b/%h exp=0/0", a_mem_rd, a_ir); end
        tick();  // N+2
        total++; if (a_ir !== 32'h8C22_0004) begin bad++; $display("FAIL ir_val got=%h exp=8c220004", a_ir); end
        total++; if (a_op !== 6'h23 || a_rs !== 5'd1 || a_rt !== 5'd2 || a_imm !== 16'h4) begin bad++; $display("FAIL ir_fields got=%h %h %h %h exp=23 01 02 0004", a_op, a_rs, a_rt, a_imm); end
        total++; if (a_rd !== 5'd0 || a_funct !== 6'd4) begin bad++; $display("FAIL ir_rd_funct got=%h %h exp=00 04", a_rd, a_funct); end
        total++; if (a_done !== 1'b1 || a_mdr !== 32'h0) begin bad++; $display("FAIL rd_done got=%b/%h exp=1/0", a_done, a_mdr); end
        tick();  // N+3
        total++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL rd_done_pulse got=%b%b exp=00", a_done, a_busy); end
        idle(5);
    endtask

    task automatic test_back_to_back();
        IouD = 1; alu_out_in = 32'h100; wdata_in = 32'hDEAD_BEEF; req_write = 1;
        tick();  // N
        req_write = 0;
        total++; if (b_mem_wr !== 1'b1 || b_mem_addr !== 32'h100 || b_mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_strobe got=%b/%h/%h exp=1/00000100/deadbeef", b_mem_wr, b_mem_addr, b_mem_wdata); end
        tick();  // N+1
        total++; if (b_mem_wr !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL wr_n1 got=%b%b exp=00", b_mem_wr, b_done); end
        tick();  // N+2
        total++; if (b_done !== 1'b1 || a_done !== 1'b1) begin bad++; $display("FAIL wr_done got=%b%b exp=11", b_done, a_done); end
        load_ir = 0; req_read = 1;  // accepted in the DONE cycle
        tick();  // M
        req_read = 0;
        total++; if (b_mem_rd !== 1'b1 || b_mem_addr !== 32'h100) begin bad++; $display("FAIL b2b_strobe got=%b/%h exp=1/00000100", b_mem_rd, b_mem_addr); end
        tick();  // M+1
        total++; if (b_busy !== 1'b1 || b_mem_rd !== 1'b0) begin bad++; $display("FAIL ld_m1 got=%b%b exp=10", b_busy, b_mem_rd); end
        tick();  // M+2
        total++; if (b_busy !== 1'b1 || b_mdr !== 32'h0) begin bad++; $display("FAIL ld_m2 got=%b/%h exp=1/0", b_busy, b_mdr); end
        total++; if (a_mdr !== 32'hDEAD_BEEF || a_done !== 1'b1) begin bad++; $display("FAIL a_ld got=%h/%b exp=deadbeef/1", a_mdr, a_done); end
        tick();  // M+3
        total++; if (b_busy !== 1'b1 || b_mdr !== 32'h0) begin bad++; $display("FAIL ld_m3 got=%b/%h exp=1/0", b_busy, b_mdr); end
        tick();  // M+4
        total++; if (b_mdr !== 32'hDEAD_BEEF || b_done !== 1'b1 || b_busy !== 1'b0) begin bad++; $display("FAIL ld_m4 got=%h/%b%b exp=deadbeef/10", b_mdr, b_done, b_busy); end
        total++; if (b_ir !== 32'h8C22_0004) begin bad++; $display("FAIL ld_ir_hold got=%h exp=8c220004", b_ir); end
        idle(3);
    endtask

    task automatic test_misaligned();
        IouD = 1; alu_out_in = 32'h102; req_read = 1;
        tick();  // N
        req_read = 0;
        total++; if (a_mem_rd !== 1'b0 || a_mis !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL mis_n got=%b%b%b exp=010", a_mem_rd, a_mis, a_busy); end
        tick();
        total++; if (a_mis !== 1'b0 || a_mem_rd !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL mis_n1 got=%b%b%b%b exp=0000", a_mis, a_mem_rd, a_done, a_busy); end
        total++; if (a_ir !== 32'h8C22_0004 || a_mdr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mis_hold got=%h/%h exp=8c220004/deadbeef", a_ir, a_mdr); end
        idle(2);
    endtask

    task automatic test_proto_err();
        IouD = 0; pc_in = 32'h40; load_ir = 0; req_read = 1; req_write = 1;
        tick();
        req_read = 0; req_write = 0;
        total++; if (a_mem_rd !== 1'b0 || a_mem_wr !== 1'b0 || a_perr !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL perr_both got=%b%b%b%b exp=0010", a_mem_rd, a_mem_wr, a_perr, a_busy); end
        idle(1);
        req_read = 1;
        tick();  // N accepted
        total++; if (a_mem_rd !== 1'b1) begin bad++; $display("FAIL perr_rd got=%b exp=1", a_mem_rd); end
        tick();  // N+1, second request seen while busy
        req_read = 0;
        total++; if (a_mem_rd !== 1'b0 || a_perr !== 1'b1) begin bad++; $display("FAIL perr_busy got=%b%b exp=01", a_mem_rd, a_perr); end
        tick();  // N+2
        total++; if (a_mdr !== 32'h8C22_0004 || a_done !== 1'b1) begin bad++; $display("FAIL perr_cap got=%h/%b exp=8c220004/1", a_mdr, a_done); end
        tick();
        total++; if (a_mem_rd !== 1'b0 || a_busy !== 1'b0 || a_perr !== 1'b1) begin bad++; $display("FAIL perr_after got=%b%b%b exp=001", a_mem_rd, a_busy, a_perr); end
        idle(5);
    endtask

    task automatic test_reset_mid_read();
        IouD = 0; pc_in = 32'h44; load_ir = 0; req_read = 1;
        tick();  // N
        req_read = 0;
        total++; if (a_mem_rd !== 1'b1) begin bad++; $display("FAIL rst_acc got=%b exp=1", a_mem_rd); end
        reset = 1'b1;
        #1;
        total++; if ({a_ir, a_mdr, a_mem_addr, a_mem_wdata} !== 128'h0 || {a_mem_rd, a_busy, a_done, a_perr} !== 4'b0) begin bad++; $display("FAIL rst_async got=%h/%b exp=0/0000", {a_ir, a_mdr, a_mem_addr, a_mem_wdata}, {a_mem_rd, a_busy, a_done, a_perr}); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (a_mdr !== 32'h0 || a_done !== 1'b0 || b_mdr !== 32'h0 || b_done !== 1'b0) begin bad++; $display("FAIL rst_nocap cyc=%0d got=%h/%b %h/%b exp=0/0", i, a_mdr, a_done, b_mdr, b_done); end
        end
        req_read = 1;
        tick();
        req_read = 0;
        total++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 32'h44) begin bad++; $display("FAIL rst_next got=%b/%h exp=1/00000044", a_mem_rd, a_mem_addr); end
        idle(2);
        total++; if (a_mdr !== 32'h1234_5678 || a_done !== 1'b1) begin bad++; $display("FAIL rst_next_cap got=%h/%b exp=12345678/1", a_mdr, a_done); end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h10] = 32'h8C22_0004;
        mem_b[8'h10] = 32'h8C22_0004;
        mem_a[8'h11] = 32'h1234_5678;
        mem_b[8'h11] = 32'h1234_5678;
        test_reset();
        test_read_ir();
        test_back_to_back();
        test_misaligned();
        test_proto_err();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
